picoblaze_s2mm_frame_limiter: RTL and testbench
===============================================

// Module: picoblaze_s2mm_frame_limiter
// PURPOSE
//  Upstream stage of the PicoBlaze DataMover bridge's S2MM stream input. Takes the received
//  Ethernet byte stream (AXI4-Stream, 8-bit, TLAST per frame) and guarantees no frame exceeds
//  the fixed 1024-byte S2MM command length. Oversized frames are truncated: TLAST is forced
//  on byte 1024 and the remainder is discarded. Passed/truncated frames are counted for firmware.
// PARAMETERS
//  C_MAX_BYTES    1024  max bytes forwarded per frame; must equal S2MM command BTT
//  C_COUNT_WIDTH  8     width of the saturating frame counters
// PORTS
//  clk                  in   1    clock; all logic on posedge
//  reset                in   1    synchronous reset, active-high
//  s_axis_tdata         in   8    received byte
//  s_axis_tvalid        in   1    byte valid
//  s_axis_tready        out  1    byte accepted when tvalid&tready
//  s_axis_tlast         in   1    last byte of frame
//  m_axis_tdata         out  8    byte to bridge S2MM input
//  m_axis_tvalid        out  1    output valid
//  m_axis_tready        in   1    bridge ready
//  m_axis_tlast         out  1    frame end (true or forced)
//  frames_passed        out  CW   frames forwarded intact, saturating
//  frames_truncated     out  CW   frames cut at C_MAX_BYTES, saturating
//  clear_counters       in   1    one-cycle pulse zeroes both counters
// BEHAVIOUR
//  - Reset: m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, counters=0, byte_cnt=0, state=PASS.
//  - Output is a single register stage: latency 1 cycle input accept -> m_axis_tvalid.
//    Register loads when empty or m_axis_tready; in PASS s_axis_tready = !m_axis_tvalid | m_axis_tready.
//    Register holds tdata/tlast stable while tvalid & !tready (AXIS rule); no combinational path tvalid->tvalid.
//  - byte_cnt: 11 bits, counts accepted bytes of current frame, 0..C_MAX_BYTES-1.
//  - State PASS, on accepted byte:
//      s_tlast=1                     -> forward, tlast=1, byte_cnt<=0, frames_passed++.
//      s_tlast=0, byte_cnt==MAX-1    -> forward, tlast forced 1, byte_cnt<=0, frames_truncated++, ->DROP.
//      otherwise                     -> forward, tlast=0, byte_cnt++.
//    Frame of exactly C_MAX_BYTES with real TLAST on byte 1024 counts as passed, not truncated.
//  - State DROP: s_axis_tready=1 unconditionally; bytes discarded, output register untouched
//    (still drains forced-TLAST byte normally). Accepted s_tlast -> PASS. No counter change.
//  - Counters saturate at all-ones. clear_counters coincident with an increment: clear wins (result 0).
//  - Single-byte frame (tlast on first byte) is legal, forwarded with tlast=1.
//  - Reset mid-frame: output byte in flight is lost, state PASS; leftover bytes of the interrupted
//    frame are treated as a new frame (firmware detects via S2MM status length).
//  - No bubbles: with m_axis_tready held 1, one byte per cycle sustained in PASS.
// STRUCTURE
//  - Shared package picoblaze_dm_pkg: S2MM_MAX_BYTES=1024 (also used for bridge S2MM BTT),
//    byte-count width constant, state encoding {PASS, DROP}.
//  - One sub-module: axis_byte_reg (1-deep 9-bit AXIS output register, data+last), reusable
//    on the MM2S side. FSM, byte counter and frame counters live in the top.
// TESTING
//  1 60-byte frame, m_tready=1 -> 60 bytes out, tlast on byte 60 only, passed=1, truncated=0, 1-cycle latency.
//  2 1500-byte frame -> 1024 bytes out, tlast on byte 1024, 476 dropped with s_tready=1, truncated=1;
//    following 64-byte frame forwarded intact, passed=1.
//  3 Exactly 1024-byte frame with tlast -> passed=1, truncated=0, state stays PASS; 1025-byte -> truncated=1.
//  4 Random m_tready (50%) over 20 mixed frames -> output byte sequence equals reference model,
//    tdata/tlast stable while stalled, no byte lost/duplicated.
//  5 frames_passed at 255, one more frame + clear_counters same cycle as its tlast -> counter reads 0;
//    without clear -> stays 255.
//  6 Assert reset at byte 500 of a 2000-byte frame -> m_tvalid=0 next cycle, counters 0, next 1024
//    bytes forwarded then truncation (tail treated as new frame).

Source files
------------

// File: rtl/picoblaze_dm_pkg.sv
// Shared constants and types for the PicoBlaze DataMover bridge.
// S2MM_MAX_BYTES also sets the S2MM command BTT on the bridge side.
package picoblaze_dm_pkg;

    localparam int unsigned S2MM_MAX_BYTES = 1024;
    localparam int unsigned S2MM_CNT_W     = $clog2(S2MM_MAX_BYTES) + 1;

    typedef logic [S2MM_CNT_W-1:0] s2mm_byte_cnt_t;

    typedef enum logic [0:0] {
        StPass,
        StDrop
    } s2mm_lim_state_e;

endpackage

// File: rtl/picoblaze_s2mm_frame_limiter_if.sv
// 8-bit AXI4-Stream byte channel with TLAST.
interface picoblaze_s2mm_frame_limiter_if;

    logic [7:0] tdata;
    logic       tvalid;
    logic       tready;
    logic       tlast;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);

endinterface

// File: rtl/axis_byte_reg.sv
// One-deep registered AXIS stage; payload is held stable while stalled.
module axis_byte_reg #(
    parameter int unsigned Width = 9
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid_i,
    input  logic [Width-1:0] in_data_i,
    output logic             in_ready_o,
    output logic             out_valid_o,
    output logic [Width-1:0] out_data_o,
    input  logic             out_ready_i
);

    logic             valid_q;
    logic [Width-1:0] data_q;

    assign in_ready_o  = !valid_q || out_ready_i;
    assign out_valid_o = valid_q;
    assign out_data_o  = data_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (in_ready_o) begin
            valid_q <= in_valid_i;
            if (in_valid_i) begin
                data_q <= in_data_i;
            end
        end
    end

endmodule

// File: rtl/picoblaze_s2mm_frame_limiter.sv
// Caps received frames at C_MAX_BYTES: forces TLAST on the last allowed byte and
// discards the remainder, counting intact and truncated frames for firmware.
module picoblaze_s2mm_frame_limiter
    import picoblaze_dm_pkg::*;
#(
    parameter int unsigned C_MAX_BYTES   = S2MM_MAX_BYTES,
    parameter int unsigned C_COUNT_WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    picoblaze_s2mm_frame_limiter_if.slave  s_axis,
    picoblaze_s2mm_frame_limiter_if.master m_axis,
    input  logic                         clear_counters_i,
    output logic [C_COUNT_WIDTH-1:0]     frames_passed_o,
    output logic [C_COUNT_WIDTH-1:0]     frames_truncated_o
);

    localparam s2mm_byte_cnt_t LastIdx = s2mm_byte_cnt_t'(C_MAX_BYTES - 1);
    localparam s2mm_byte_cnt_t CntOne  = s2mm_byte_cnt_t'(1);

    s2mm_lim_state_e          state_q;
    s2mm_byte_cnt_t           byte_cnt_q;
    logic [C_COUNT_WIDTH-1:0] passed_q;
    logic [C_COUNT_WIDTH-1:0] trunc_q;

    logic       reg_in_valid;
    logic       reg_in_ready;
    logic       reg_out_valid;
    logic [8:0] reg_out_data;
    logic       at_limit;
    logic       accept;

    assign at_limit     = (byte_cnt_q == LastIdx);
    assign reg_in_valid = s_axis.tvalid && (state_q == StPass);
    // Dropping never back-pressures, so the tail drains at line rate.
    assign s_axis.tready = (state_q == StDrop) ? 1'b1 : reg_in_ready;
    assign accept        = s_axis.tvalid && s_axis.tready;

    axis_byte_reg #(
        .Width (9)
    ) u_out_reg (
        .clk         (clk),
        .reset       (reset),
        .in_valid_i  (reg_in_valid),
        .in_data_i   ({s_axis.tlast || at_limit, s_axis.tdata}),
        .in_ready_o  (reg_in_ready),
        .out_valid_o (reg_out_valid),
        .out_data_o  (reg_out_data),
        .out_ready_i (m_axis.tready)
    );

    assign m_axis.tvalid = reg_out_valid;
    assign m_axis.tdata  = reg_out_data[7:0];
    assign m_axis.tlast  = reg_out_data[8];

    assign frames_passed_o    = passed_q;
    assign frames_truncated_o = trunc_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StPass;
            byte_cnt_q <= '0;
            passed_q   <= '0;
            trunc_q    <= '0;
        end else begin
            if (accept) begin
                unique case (state_q)
                    StPass: begin
                        if (s_axis.tlast) begin
                            byte_cnt_q <= '0;
                            if (passed_q != '1) passed_q <= passed_q + 1'b1;
                        end else if (at_limit) begin
                            byte_cnt_q <= '0;
                            state_q    <= StDrop;
                            if (trunc_q != '1) trunc_q <= trunc_q + 1'b1;
                        end else begin
                            byte_cnt_q <= byte_cnt_q + CntOne;
                        end
                    end
                    StDrop: begin
                        if (s_axis.tlast) state_q <= StPass;
                    end
                    default: state_q <= StPass;
                endcase
            end
            // Placed last so a clear overrides a same-cycle increment.
            if (clear_counters_i) begin
                passed_q <= '0;
                trunc_q  <= '0;
            end
        end
    end

endmodule

// File: tb/tb_picoblaze_s2mm_frame_limiter.sv
// Directed bench for the S2MM frame limiter: scoreboard of expected output bytes
// built from frame lengths, plus counter, latency and throughput checks.
module tb_picoblaze_s2mm_frame_limiter;

    localparam int MaxBytes = 1024;

    logic       clk;
    logic       reset;
    logic       clear_counters;
    logic [7:0] frames_passed;
    logic [7:0] frames_truncated;

    picoblaze_s2mm_frame_limiter_if s_axis ();
    picoblaze_s2mm_frame_limiter_if m_axis ();

    picoblaze_s2mm_frame_limiter dut (
        .clk                (clk),
        .reset              (reset),
        .s_axis             (s_axis),
        .m_axis             (m_axis),
        .clear_counters_i   (clear_counters),
        .frames_passed_o    (frames_passed),
        .frames_truncated_o (frames_truncated)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit rand_ready = 0;
    bit mark_first = 0;
    int acc_first_cyc = -1;
    int out_first_cyc = -2;
    logic [8:0] exp_q[$];

    initial clk = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        m_axis.tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            m_axis.tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Output monitor: scoreboard compare on every transfer, hold check while stalled.
    initial begin
        bit         prev_stall = 0;
        logic [7:0] prev_data  = '0;
        logic       prev_last  = 0;
        logic [8:0] e;
        forever begin
            @(negedge clk);
            if (mark_first && m_axis.tvalid === 1'b1) begin
                out_first_cyc = cyc;
                mark_first    = 0;
            end
            if (!reset && prev_stall) begin
                total++;
                if (m_axis.tvalid !== 1'b1 || m_axis.tdata !== prev_data ||
                    m_axis.tlast !== prev_last) begin
                    bad++;
                    $display("FAIL stall_hold: got v=%b d=%h l=%b want v=1 d=%h l=%b",
                             m_axis.tvalid, m_axis.tdata, m_axis.tlast, prev_data, prev_last);
                end
            end
            if (m_axis.tvalid === 1'b1 && m_axis.tready === 1'b1) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL out_extra: got last=%b data=%h want no transfer",
                             m_axis.tlast, m_axis.tdata);
                end else begin
                    e = exp_q.pop_front();
                    if ({m_axis.tlast, m_axis.tdata} !== e) begin
                        bad++;
                        $display("FAIL out_byte: got last=%b data=%h want last=%b data=%h",
                                 m_axis.tlast, m_axis.tdata, e[8], e[7:0]);
                    end
                end
            end
            prev_stall = !reset && m_axis.tvalid === 1'b1 && m_axis.tready !== 1'b1;
            prev_data  = m_axis.tdata;
            prev_last  = m_axis.tlast;
        end
    end

    task automatic do_reset();
        reset          = 1'b1;
        s_axis.tvalid  = 1'b0;
        s_axis.tlast   = 1'b0;
        s_axis.tdata   = '0;
        clear_counters = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Drives bytes [0, stop) of a len-byte frame; pushes what the limiter should emit.
    task automatic drive_frame(input int len, input int base, input bit clr_last,
                               input int stop, output int cycles);
        bit ok;
        int w;
        cycles = 0;
        for (int i = 0; i < stop; i++) begin
            s_axis.tvalid  = 1'b1;
            s_axis.tdata   = 8'(base + i);
            s_axis.tlast   = (i == len - 1);
            clear_counters = clr_last && (i == len - 1);
            w = 0;
            do begin
                @(negedge clk);
                ok = (s_axis.tready === 1'b1);
                @(posedge clk);
                #1;
                cycles++;
                w++;
            end while (!ok && w < 200);
            if (!ok) begin
                total++;
                bad++;
                $display("FAIL in_timeout: byte %0d not accepted within %0d cycles", i, w);
                break;
            end
            if (i == 0) acc_first_cyc = cyc;
            if (i < MaxBytes)
                exp_q.push_back({(i == len - 1) || (i == MaxBytes - 1), 8'(base + i)});
        end
        s_axis.tvalid  = 1'b0;
        s_axis.tlast   = 1'b0;
        clear_counters = 1'b0;
    endtask

    task automatic wait_drain();
        int w = 0;
        while ((exp_q.size() != 0 || m_axis.tvalid === 1'b1) && w < 20000) begin
            @(posedge clk);
            #1;
            w++;
        end
        total++;
        if (exp_q.size() != 0 || m_axis.tvalid === 1'b1) begin
            bad++;
            $display("FAIL drain: got %0d bytes outstanding want 0", exp_q.size());
        end
    endtask

    task automatic check_counts(input string tag, input int p, input int t);
        total += 2;
        if (frames_passed !== 8'(p)) begin
            bad++;
            $display("FAIL %s_passed: got %0d want %0d", tag, frames_passed, p);
        end
        if (frames_truncated !== 8'(t)) begin
            bad++;
            $display("FAIL %s_truncated: got %0d want %0d", tag, frames_truncated, t);
        end
    endtask

    task automatic test_reset();
        do_reset();
        total += 4;
        if (m_axis.tvalid !== 1'b0) begin
            bad++; $display("FAIL rst_tvalid: got %b want 0", m_axis.tvalid);
        end
        if (m_axis.tlast !== 1'b0) begin
            bad++; $display("FAIL rst_tlast: got %b want 0", m_axis.tlast);
        end
        if (m_axis.tdata !== 8'h00) begin
            bad++; $display("FAIL rst_tdata: got %h want 00", m_axis.tdata);
        end
        if (s_axis.tready !== 1'b1) begin
            bad++; $display("FAIL rst_tready: got %b want 1", s_axis.tready);
        end
        check_counts("rst", 0, 0);
    endtask

    task automatic test_basic();
        int c;
        do_reset();
        mark_first = 1;
        drive_frame(60, 8'h10, 0, 60, c);
        wait_drain();
        total += 2;
        if (out_first_cyc !== acc_first_cyc) begin
            bad++;
            $display("FAIL latency: got out cycle %0d want %0d", out_first_cyc, acc_first_cyc);
        end
        if (c !== 60) begin
            bad++; $display("FAIL basic_cycles: got %0d want 60", c);
        end
        check_counts("basic", 1, 0);
    endtask

    task automatic test_truncate();
        int c;
        do_reset();
        drive_frame(1500, 8'h33, 0, 1500, c);
        total++;
        if (c !== 1500) begin
            bad++; $display("FAIL trunc_cycles: got %0d want 1500", c);
        end
        drive_frame(64, 8'hA0, 0, 64, c);
        total++;
        if (c !== 64) begin
            bad++; $display("FAIL after_trunc_cycles: got %0d want 64", c);
        end
        wait_drain();
        check_counts("trunc", 1, 1);
    endtask

    task automatic test_boundary();
        int c;
        do_reset();
        drive_frame(1024, 8'h05, 0, 1024, c);
        wait_drain();
        check_counts("exact", 1, 0);
        drive_frame(5, 8'hE0, 0, 5, c);
        wait_drain();
        check_counts("exact_next", 2, 0);
        drive_frame(1025, 8'h77, 0, 1025, c);
        drive_frame(1, 8'h99, 0, 1, c);
        wait_drain();
        check_counts("over1", 3, 1);
    endtask

    task automatic test_random_ready();
        int lens[20] = '{1, 2, 17, 64, 1, 1024, 1025, 5, 300, 1,
                         9, 1030, 60, 2, 128, 1, 40, 3, 1024, 7};
        int p = 0;
        int t = 0;
        int c;
        do_reset();
        rand_ready = 1;
        for (int f = 0; f < 20; f++) begin
            drive_frame(lens[f], f * 13, 0, lens[f], c);
            if (lens[f] <= MaxBytes) p++;
            else t++;
        end
        wait_drain();
        rand_ready = 0;
        @(posedge clk);
        #1;
        check_counts("random", p, t);
    endtask

    task automatic test_saturate();
        int c;
        do_reset();
        for (int f = 0; f < 255; f++) drive_frame(1, f, 0, 1, c);
        wait_drain();
        check_counts("sat255", 255, 0);
        drive_frame(1, 8'h42, 1, 1, c);
        wait_drain();
        check_counts("sat_clear", 0, 0);
        for (int f = 0; f < 256; f++) drive_frame(1, f, 0, 1, c);
        wait_drain();
        check_counts("sat_hold", 255, 0);
    endtask

    task automatic test_reset_mid();
        int c;
        do_reset();
        drive_frame(10, 8'h20, 0, 10, c);
        drive_frame(2000, 8'h00, 0, 500, c);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        total++;
        if (m_axis.tvalid !== 1'b0) begin
            bad++; $display("FAIL midrst_tvalid: got %b want 0", m_axis.tvalid);
        end
        check_counts("midrst", 0, 0);
        total++;
        if (exp_q.size() != 0) begin
            bad++; $display("FAIL midrst_pending: got %0d want 0", exp_q.size());
            exp_q.delete();
        end
        drive_frame(1500, 500, 0, 1500, c);
        wait_drain();
        check_counts("midrst_tail", 0, 1);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_truncate();
        test_boundary();
        test_random_ready();
        test_saturate();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
